// File: rtl/kbd_game_ctrl.sv
// kbd_game_ctrl
//   Turns keyboard make/brake events into per-frame game controls.
//   Tracks held state for left, right, fire and pause keys. Resolves
//   left/right conflicts in favour of the most recently pressed direction.
//   Rate-limits shots with a frame-based cooldown and toggles pause.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   keyCode    : 9-bit scan code, bit 8 = extended (E0) flag
//   make       : one-clk key press / typematic repeat strobe
//   brake      : one-clk key release strobe
//   frame_tick : one-clk pulse per video frame
//   move_left  : registered, player moves left this frame
//   move_right : registered, player moves right this frame
//   fire_pulse : one-clk shot request
//   paused     : game pause state
module kbd_game_ctrl #(
    parameter logic [8:0] LEFT_CODE     = 9'h16B,
    parameter logic [8:0] RIGHT_CODE    = 9'h174,
    parameter logic [8:0] FIRE_CODE     = 9'h029,
    parameter logic [8:0] PAUSE_CODE    = 9'h04D,
    parameter int         FIRE_COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brake,
    input  logic       frame_tick,
    output logic       move_left,
    output logic       move_right,
    output logic       fire_pulse,
    output logic       paused
);

    localparam logic [7:0] COOLDOWN_LOAD = 8'(FIRE_COOLDOWN);

    logic       left_held,  left_held_n;
    logic       right_held, right_held_n;
    logic       fire_held,  fire_held_n;
    logic       pause_held, pause_held_n;
    logic       last_dir,   last_dir_n;
    logic       fire_pending, fire_pending_n;
    logic [7:0] cooldown,   cooldown_n;
    logic       paused_n;
    logic       move_left_n, move_right_n, fire_pulse_n;

    // Decoded key events. make takes priority over brake in the same cycle.
    logic is_left, is_right, is_fire, is_pause;
    logic fire_press, fire_release, pause_press, shoot;

    always_comb begin
        is_left  = (keyCode == LEFT_CODE);
        is_right = (keyCode == RIGHT_CODE);
        is_fire  = (keyCode == FIRE_CODE);
        is_pause = (keyCode == PAUSE_CODE);

        // Only the first make of a held key counts as a press.
        fire_press   = make && is_fire && !fire_held;
        fire_release = !make && brake && is_fire;
        pause_press  = make && is_pause && !pause_held;

        // A shot is taken from a fresh press or from a pending press that
        // is still held once the cooldown has run out. Both test the
        // cooldown value before this cycle's frame_tick decrement.
        shoot = !paused && (cooldown == 8'd0) &&
                (fire_press || (fire_pending && fire_held && !fire_release));

        left_held_n  = left_held;
        right_held_n = right_held;
        fire_held_n  = fire_held;
        pause_held_n = pause_held;
        last_dir_n   = last_dir;

        if (make) begin
            if (is_left)  left_held_n  = 1'b1;
            if (is_right) right_held_n = 1'b1;
            if (is_fire)  fire_held_n  = 1'b1;
            if (is_pause) pause_held_n = 1'b1;
            // Direction only follows fresh presses, not typematic repeats.
            if (is_left  && !left_held)  last_dir_n = 1'b0;
            if (is_right && !right_held) last_dir_n = 1'b1;
        end else if (brake) begin
            if (is_left)  left_held_n  = 1'b0;
            if (is_right) right_held_n = 1'b0;
            if (is_fire)  fire_held_n  = 1'b0;
            if (is_pause) pause_held_n = 1'b0;
        end

        paused_n = pause_press ? !paused : paused;

        // Cooldown freezes while paused; a shot reload overrides the tick.
        cooldown_n = cooldown;
        if (shoot)
            cooldown_n = COOLDOWN_LOAD;
        else if (frame_tick && !paused && (cooldown != 8'd0))
            cooldown_n = cooldown - 8'd1;

        fire_pending_n = fire_pending;
        if (fire_press && !paused && (cooldown != 8'd0))
            fire_pending_n = 1'b1;
        if (shoot || fire_release || paused || (pause_press && !paused))
            fire_pending_n = 1'b0;

        fire_pulse_n = shoot && !fire_pulse;

        // Outputs follow the post-update state so a key change or pause
        // exit shows up on the very next cycle.
        move_left_n  = !paused_n && left_held_n &&
                       (!right_held_n || (last_dir_n == 1'b0));
        move_right_n = !paused_n && right_held_n &&
                       (!left_held_n || (last_dir_n == 1'b1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_held    <= 1'b0;
            right_held   <= 1'b0;
            fire_held    <= 1'b0;
            pause_held   <= 1'b0;
            last_dir     <= 1'b0;
            fire_pending <= 1'b0;
            cooldown     <= 8'd0;
            paused       <= 1'b0;
            move_left    <= 1'b0;
            move_right   <= 1'b0;
            fire_pulse   <= 1'b0;
        end else begin
            left_held    <= left_held_n;
            right_held   <= right_held_n;
            fire_held    <= fire_held_n;
            pause_held   <= pause_held_n;
            last_dir     <= last_dir_n;
            fire_pending <= fire_pending_n;
            cooldown     <= cooldown_n;
            paused       <= paused_n;
            move_left    <= move_left_n;
            move_right   <= move_right_n;
            fire_pulse   <= fire_pulse_n;
        end
    end

endmodule

// File: tb/tb_kbd_game_ctrl.sv
module tb_kbd_game_ctrl;

    localparam logic [8:0] LEFT  = 9'h16B;
    localparam logic [8:0] RIGHT = 9'h174;
    localparam logic [8:0] FIRE  = 9'h029;
    localparam logic [8:0] PAUSE = 9'h04D;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] keyCode;
    logic       make;
    logic       brake;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic       fire_pulse;
    logic       paused;

    int n_checks = 0;
    int n_fail   = 0;

    kbd_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .keyCode    (keyCode),
        .make       (make),
        .brake      (brake),
        .frame_tick (frame_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .fire_pulse (fire_pulse),
        .paused     (paused)
    );

    // clock
    always #5 clk = ~clk;

    // comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drivers: apply inputs for one cycle, return at the following negedge
    task automatic key(input logic m, input logic b, input logic [8:0] code);
        @(negedge clk);
        keyCode = code; make = m; brake = b;
        @(negedge clk);
        make = 1'b0; brake = 1'b0; keyCode = 9'h000;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic chk_outs(input string tag, input logic ml, input logic mr,
                            input logic fp, input logic pz);
        chk({tag, "_ml"}, 32'(move_left),  32'(ml));
        chk({tag, "_mr"}, 32'(move_right), 32'(mr));
        chk({tag, "_fp"}, 32'(fire_pulse), 32'(fp));
        chk({tag, "_pz"}, 32'(paused),     32'(pz));
    endtask

    initial begin
        reset = 1'b1; keyCode = 9'h000; make = 1'b0; brake = 1'b0; frame_tick = 1'b0;
        #3;
        chk_outs("reset", 0, 0, 0, 0);
        chk("reset_cd", 32'(dut.cooldown), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // first press fires immediately; repeats do not
        key(1, 0, FIRE);
        chk("fire1", 32'(fire_pulse), 32'd1);
        chk("cd_load", 32'(dut.cooldown), 32'd8);
        idle();
        chk("fire1_one_clk", 32'(fire_pulse), 32'd0);
        for (int i = 0; i < 3; i++) begin
            key(1, 0, FIRE);
            chk("repeat_nofire", 32'(fire_pulse), 32'd0);
        end

        // press during cooldown, kept held -> fires when cooldown reaches 0
        key(0, 1, FIRE);
        tick(); tick();
        chk("cd_after2", 32'(dut.cooldown), 32'd6);
        key(1, 0, FIRE);
        chk("pending_nofire", 32'(fire_pulse), 32'd0);
        chk("pending_set", 32'(dut.fire_pending), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pending_wait", 32'(fire_pulse), 32'd0);
        end
        chk("cd_zero", 32'(dut.cooldown), 32'd0);
        idle();
        chk("pending_fire", 32'(fire_pulse), 32'd1);
        idle();
        chk("pending_fire_one", 32'(fire_pulse), 32'd0);
        chk("cd_reload", 32'(dut.cooldown), 32'd8);

        // press during cooldown, released early -> no shot
        key(0, 1, FIRE);
        key(1, 0, FIRE);
        tick(); tick(); tick();
        key(0, 1, FIRE);
        chk("release_clears", 32'(dut.fire_pending), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("released_nofire", 32'(fire_pulse), 32'd0);
        end

        // direction arbitration
        key(1, 0, LEFT);
        chk_outs("left", 1, 0, 0, 0);
        key(1, 0, RIGHT);
        chk_outs("left_right", 0, 1, 0, 0);
        key(0, 1, RIGHT);
        chk_outs("right_released", 1, 0, 0, 0);
        key(1, 0, RIGHT);
        key(1, 0, LEFT);   // typematic repeat of held left: direction stays right
        chk_outs("left_repeat", 0, 1, 0, 0);
        key(0, 1, RIGHT);
        key(0, 1, LEFT);
        chk_outs("none_held", 0, 0, 0, 0);

        // make and brake together: make wins
        key(1, 1, LEFT);
        chk("mk_brk_held", 32'(dut.left_held), 32'd1);
        chk("mk_brk_move", 32'(move_left), 32'd1);

        // untracked code is ignored
        key(1, 0, 9'h01C);
        chk_outs("untracked", 1, 0, 0, 0);

        // pause: left still held, start a cooldown of 5
        key(1, 0, FIRE);
        chk("fire_pre_pause", 32'(fire_pulse), 32'd1);
        key(0, 1, FIRE);
        tick(); tick(); tick();
        chk("cd5", 32'(dut.cooldown), 32'd5);
        key(1, 0, PAUSE);
        chk_outs("pause_on", 0, 0, 0, 1);
        key(1, 0, PAUSE);
        chk("pause_repeat", 32'(paused), 32'd1);
        key(0, 1, PAUSE);
        tick(); tick();
        chk("cd_frozen", 32'(dut.cooldown), 32'd5);
        key(1, 0, FIRE);
        chk("paused_fire", 32'(fire_pulse), 32'd0);
        chk("paused_nopend", 32'(dut.fire_pending), 32'd0);
        key(0, 1, FIRE);
        key(1, 1, PAUSE);
        chk_outs("pause_off", 1, 0, 0, 0);
        key(0, 1, PAUSE);

        // async reset mid-cooldown and mid-pause
        key(1, 0, PAUSE);
        chk("pause_again", 32'(paused), 32'd1);
        chk("cd_still5", 32'(dut.cooldown), 32'd5);
        #2 reset = 1'b1;
        #1;
        chk_outs("async_reset", 0, 0, 0, 0);
        chk("async_cd", 32'(dut.cooldown), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle();
        chk_outs("post_reset", 0, 0, 0, 0);
        key(1, 0, FIRE);
        chk("post_reset_fire", 32'(fire_pulse), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_game_ctrl.md
KBD_GAME_CTRL -- requirements
Module: kbd_game_ctrl

Interface
REQ-001 Parameter LEFT_CODE, default 9'h16B, keyCode of the left-arrow key (extended).
REQ-002 Parameter RIGHT_CODE, default 9'h174, keyCode of the right-arrow key (extended).
REQ-003 Parameter FIRE_CODE, default 9'h029, keyCode of the space bar.
REQ-004 Parameter PAUSE_CODE, default 9'h04D, keyCode of the P key.
REQ-005 Parameter FIRE_COOLDOWN, default 8, number of frame_tick pulses between shots (range 1..255).
REQ-006 Port clk, input, 1, the single system clock.
REQ-007 Port reset, input, 1: one clock; reset is asynchronous and active-high.
REQ-008 Port keyCode, input, 9, scan code from the keyboard interface; bit 8 is the extended (E0) flag.
REQ-009 Port make, input, 1, one-clk pulse: key press (or typematic repeat) of keyCode.
REQ-010 Port brake, input, 1, one-clk pulse: key release of keyCode.
REQ-011 Port frame_tick, input, 1, one-clk pulse per video frame.
REQ-012 Port move_left, output, 1, player moves left this frame.
REQ-013 Port move_right, output, 1, player moves right this frame.
REQ-014 Port fire_pulse, output, 1, one-clk shot request.
REQ-015 Port paused, output, 1, game pause state.

Function
REQ-016 Internal registers SHALL be left_held, right_held, fire_held, pause_held, last_dir (0=left, 1=right), fire_pending, cooldown[7:0] and paused; all update on rising clk.
REQ-017 keyCode SHALL be sampled only in cycles where make or brake is 1; codes not matching a parameter SHALL be ignored.
REQ-018 make with a tracked code SHALL set that key's held bit; brake SHALL clear it; if make and brake are both 1, make SHALL win and brake is ignored.
REQ-019 A make on LEFT_CODE SHALL set last_dir=0; a make on RIGHT_CODE SHALL set last_dir=1; this happens only when the held bit was 0, so typematic repeats do not change last_dir.
REQ-020 move_left SHALL be registered: 1 when not paused and left_held and (not right_held or last_dir=0); move_right is symmetric; the two SHALL never both be 1.
REQ-021 A fire press is a make on FIRE_CODE while fire_held=0; a repeat make while fire_held=1 SHALL NOT count as a press.
REQ-022 On a fire press, when not paused and cooldown=0 in that cycle: fire_pulse=1 in the next cycle (latency 1) and cooldown loads FIRE_COOLDOWN.
REQ-023 On a fire press, when not paused and cooldown!=0: fire_pending SHALL be set.
REQ-024 When fire_pending=1, cooldown=0, fire_held=1 and not paused: fire_pulse SHALL be 1 next cycle, fire_pending SHALL clear, and cooldown SHALL reload.
REQ-025 A brake on FIRE_CODE SHALL clear fire_pending.
REQ-026 cooldown SHALL decrement by 1 on each frame_tick while not paused; it saturates at 0 and never wraps.
REQ-027 The cooldown test in REQ-022 SHALL use the pre-update value when frame_tick and the press coincide.
REQ-028 fire_pulse SHALL be 1 for exactly one clk per shot and never on consecutive cycles.
REQ-029 A make on PAUSE_CODE while pause_held=0 SHALL toggle paused; repeats SHALL NOT toggle it.
REQ-030 While paused, held bits SHALL still track make/brake, cooldown SHALL freeze, fire presses SHALL be discarded without setting fire_pending, and fire_pending SHALL be cleared on pause entry.
REQ-031 Leaving pause SHALL restore move outputs from the current held bits on the next cycle.

Reset
REQ-032 While reset=1, asynchronously: all held bits, last_dir, fire_pending, paused, move_left, move_right and fire_pulse SHALL be 0, and cooldown SHALL be 0.
REQ-033 Reset mid-cooldown or mid-pause SHALL discard all state; after reset deasserts, the first fire press SHALL fire at once.

Verification
REQ-034 Release reset, make 0x029 -> fire_pulse=1 for 1 clk one cycle later; then 3 repeat makes -> no further pulse.
REQ-035 Fire, brake, make 0x029 again after 2 frame_ticks (FIRE_COOLDOWN=8) -> no pulse; keep held for 6 more ticks -> fire_pulse when cooldown hits 0; released before then -> no pulse.
REQ-036 Make 0x16B, then make 0x174 -> move_right=1, move_left=0; brake 0x174 -> move_left=1 next cycle.
REQ-037 Make and brake on 0x16B asserted in the same cycle -> left_held=1, move_left=1.
REQ-038 Make 0x04D -> paused=1, move outputs 0, ticks do not change cooldown, fire ignored; second make/brake of 0x04D -> paused=0.
REQ-039 Assert reset with cooldown=5 and paused=1 -> all outputs 0 immediately (without a clk edge); after release, fire press -> fire_pulse.
